// File: rtl/uart_pkg.sv
// Shared UART definitions: default payload width, echo FIFO read-FSM states
// and the transmitter busy-handshake timeout.
package uart_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 8;

    // Cycles the echo FIFO waits for tx_busy before treating a byte as sent.
    localparam int BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } echo_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset; the owner
// tracks validity through its own pointers.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo-path byte buffer between uart_rx and uart_tx: buffers received bytes
// in a circular FIFO and replays them through the tx enable/busy handshake.
// Optional feature: define UART_ECHO_FIFO_DROP_CNT_EN to add the saturating
// drop_cnt output counting bytes discarded while the FIFO was full.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int DEPTH        = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    tx_busy,
    output logic                    tx_en,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic [PAYLOAD_BITS-1:0] last_rx,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    full,
    output logic                    overrun,
    input  logic                    clr_overrun
`ifdef UART_ECHO_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    logic [AW-1:0]           wp_reg, rp_reg;
    logic [LW-1:0]           level_reg, level_next;
    logic                    empty_reg, full_reg, overrun_reg;
    logic                    avail_reg;
    logic [PAYLOAD_BITS-1:0] last_rx_reg;
    logic [PAYLOAD_BITS-1:0] tx_data_reg;
    logic                    tx_en_reg;
    logic [TW-1:0]           timer_reg;
    echo_fifo_state_t        state_reg;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    push, pop, drop;

    // avail_reg is a one-cycle delayed "not empty" view; it sets the
    // two-edge rx-to-tx latency. Pairing it with empty_reg keeps a pop from
    // ever hitting an empty FIFO, since only pops can make it empty.
    assign pop  = (state_reg == IDLE) && avail_reg && !empty_reg && !tx_busy;
    assign push = rx_valid && (!full_reg || pop);
    assign drop = rx_valid && full_reg && !pop;

    uart_fifo_mem #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wp_reg),
        .wr_data (rx_data),
        .rd_addr (rp_reg),
        .rd_data (rd_data)
    );

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LW'(1);
        end else if (pop && !push) begin
            level_next = level_reg - LW'(1);
        end
    end

    // FIFO bookkeeping: pointers, level, flags, last byte and sticky overrun.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_reg      <= '0;
            rp_reg      <= '0;
            level_reg   <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            avail_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            last_rx_reg <= '0;
        end else begin
            if (push) begin
                wp_reg      <= wp_reg + AW'(1);
                last_rx_reg <= rx_data;
            end
            if (pop) begin
                rp_reg <= rp_reg + AW'(1);
            end
            level_reg <= level_next;
            empty_reg <= (level_next == '0);
            full_reg  <= (level_next == LW'(DEPTH));
            avail_reg <= !empty_reg;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    // Read FSM: issue one byte, wait for busy to rise (bounded), then fall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            tx_en_reg   <= 1'b0;
            tx_data_reg <= '0;
            timer_reg   <= '0;
        end else begin
            tx_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_data_reg <= rd_data;
                        tx_en_reg   <= 1'b1;
                        timer_reg   <= '0;
                        state_reg   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef UART_ECHO_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    // Saturating count of full-drops; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_reg <= '0;
        end else if (clr_overrun) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    assign tx_en   = tx_en_reg;
    assign tx_data = tx_data_reg;
    assign last_rx = last_rx_reg;
    assign level   = level_reg;
    assign empty   = empty_reg;
    assign full    = full_reg;
    assign overrun = overrun_reg;

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Byte buffer that sits between the UART receiver and the UART transmitter inside the echo path of `uart_top`. It captures each byte the receiver flags valid and stores it in a circular FIFO. It then replays the bytes one at a time into the transmitter using the transmitter's enable/busy handshake. This lets back-to-back received frames be echoed without loss while the transmitter is still sending. It also reports fill level and a sticky overrun flag.

## Interface
Parameters:
- `PAYLOAD_BITS`, 8, data bits per byte; matches uart_rx/uart_tx.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle pulse from uart_rx: `rx_data` is valid.
- `rx_data`  in  PAYLOAD_BITS  received byte.
- `tx_busy`  in  1  uart_tx is transmitting a frame.
- `tx_en`  out  1  one-cycle request to uart_tx to start a frame.
- `tx_data`  out  PAYLOAD_BITS  byte for uart_tx; held stable from the `tx_en` cycle until `tx_busy` falls.
- `last_rx`  out  PAYLOAD_BITS  most recently accepted byte; drives led_out.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `empty`  out  1  level == 0.
- `full`  out  1  level == DEPTH.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `clr_overrun`  in  1  synchronous clear of `overrun` (and of the counter, if configured).

## Operation
- Storage: DEPTH × PAYLOAD_BITS array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits. Both wrap modulo DEPTH.
- Occupancy: `level` is a separate counter.
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen together.
- Push: `rx_valid` and (not full, or a pop in the same cycle). Writes `mem[wp]`, increments `wp`, and loads `last_rx`.
- Full-drop: `rx_valid` while full with no pop in the same cycle. The byte is discarded, `overrun` is set to 1, and `last_rx` is unchanged.
- `clr_overrun` together with a full-drop in the same cycle: set wins (`overrun` stays 1).
- Read FSM states:
  - IDLE: if not empty and `tx_busy` is 0, pop `mem[rp]` into `tx_data`, increment `rp`, pulse `tx_en`, and go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy` is 1, go to WAIT_DONE. If `tx_busy` is not seen within 4 cycles, return to IDLE; the byte is considered sent.
  - WAIT_DONE: when `tx_busy` is 0, return to IDLE.
- `tx_en` is never high for two consecutive cycles. `tx_data` only changes in a cycle where `tx_en` is high.
- Break bytes (0x00) are ordinary data and are buffered and echoed.
- Reset mid-operation: all FIFO contents are discarded and the FSM returns to IDLE. A frame uart_tx is already sending is not aborted by this block.

## Timing
- Reset values:
  - `tx_en`=0, `tx_data`=0, `last_rx`=0.
  - `level`=0, `empty`=1, `full`=0, `overrun`=0.
  - `wp`=`rp`=0, FSM=IDLE.
- All outputs are registered.
- Latency, empty FIFO with idle transmitter: if `rx_valid` is sampled at edge E0, then `tx_en` is high in the cycle after edge E0+2 (the FSM sees `level`=1 at E0+1 and issues at E0+2).
- `level`, `empty`, `full` and `last_rx` update on the same edge that samples `rx_valid`.
- Throughput: one byte per transmitter frame, plus 2 cycles of FSM overhead.

## Configuration
- `UART_ECHO_FIFO_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [7:0].
  - Counts full-drops, saturating at 255.
  - Reset to 0 by `resetn` or by `clr_overrun`; `clr_overrun` wins over increment.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `uart_pkg` holds:
  - `PAYLOAD_BITS` default.
  - Enum `echo_fifo_state_t` {IDLE, WAIT_BUSY, WAIT_DONE}.
  - Localparam `BUSY_TIMEOUT` = 4.
- One sub-module, `uart_fifo_mem`: simple dual-port register array (write port, asynchronous read port), parameterised by width and depth.
- Pointers, level, flags and FSM stay in `uart_echo_fifo`.

## Test plan
- Reset, then a single `rx_valid` with 0x41 and `tx_busy` tied to a uart_tx model:
  - `tx_en` is high exactly 2 edges later with `tx_data`=0x41.
  - `last_rx`=0x41; `level` goes 0→1→0.
- Push 0x10..0x1F (16 bytes) while `tx_busy` is held 1:
  - `full`=1, `level`=16, `overrun`=0.
  - On release, bytes emerge 0x10..0x1F in order.
- Push 17 bytes with `tx_busy` held 1:
  - The 17th byte is dropped, `overrun`=1, `last_rx`=16th byte.
  - With the macro defined, `drop_cnt`=1.
  - `clr_overrun` returns `overrun` to 0.
- FIFO full and FSM popping in the same cycle as `rx_valid`=0xAA:
  - 0xAA is accepted, `level` stays 16, `overrun` stays 0.
- `tx_busy` never asserts after `tx_en`:
  - FSM returns to IDLE after 4 cycles and issues the next byte.
  - No two-cycle `tx_en` pulse.
- Assert `resetn`=0 with `level`=5 during WAIT_DONE:
  - All outputs return to reset values.
  - Next push of 0xAD is echoed as the first `tx_data`.
